module_arbitro_uart_tx: RTL

- Round-robin scheduler that shares one UART transmit engine among N_REQ byte requesters, e.g. CPU-mapped TX register, debug dump path, echo path.
- Sits between the requesters and the UART core's start/busy/done interface.
- Serialises requests and issues exactly one tx_start per granted byte.
- Returns a per-requester completion acknowledge; a watchdog aborts transfers the UART never completes.

---
 rtl/module_arbitro_uart_tx_if.sv | 25 ++
 rtl/module_arbitro_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/module_arbitro_uart_tx_if.sv
// Requester and UART-core handshake bundle for the UART transmit arbiter.
// The slave modport is the arbiter's view; master is the environment driving it.
interface module_arbitro_uart_tx_if #(
   parameter int N_REQ = 3
);
   logic [N_REQ-1:0]   req_i;
   logic [8*N_REQ-1:0] data_i;
   logic [N_REQ-1:0]   ack_o;
   logic               err_o;
   logic [N_REQ-1:0]   grant_o;
   logic               tx_start_o;
   logic [7:0]         tx_data_o;
   logic               tx_busy_i;
   logic               tx_done_i;

   modport slave (
      input  req_i, data_i, tx_busy_i, tx_done_i,
      output ack_o, err_o, grant_o, tx_start_o, tx_data_o
   );

   modport master (
      output req_i, data_i, tx_busy_i, tx_done_i,
      input  ack_o, err_o, grant_o, tx_start_o, tx_data_o
   );
endinterface

// File: rtl/module_arbitro_uart_tx.sv
// Round-robin arbiter sharing one UART transmit engine among N_REQ byte requesters,
// with a per-requester acknowledge and a tx_start-to-tx_done watchdog.
module module_arbitro_uart_tx #(
   parameter int N_REQ       = 3,
   parameter int TIMEOUT_CYC = 2000
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   module_arbitro_uart_tx_if.slave bus
);
   localparam int LW = $clog2(N_REQ);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [LW-1:0] LAST_RST   = LW'(N_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_WAIT  = 3'd2,
      S_ACK   = 3'd3,
      S_ABORT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       data_q, data_d;
   logic             start_q, start_d;
   logic             err_q, err_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [LW-1:0]    last_q, last_d;
   logic [LW-1:0]    owner_q, owner_d;

   logic             hi_found_s, lo_found_s, win_found_s;
   logic [LW-1:0]    hi_idx_s, lo_idx_s, win_idx_s;
   logic [N_REQ-1:0] win_onehot_s;
   logic [7:0]       win_byte_s;

   // Round-robin scan: lowest requester above last grant, else lowest overall (wrap).
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = {LW{1'b0}};
      lo_idx_s   = {LW{1'b0}};
      for (int k = N_REQ - 1; k >= 0; k--) begin
         lo_found_s = lo_found_s | bus.req_i[k];
         lo_idx_s   = bus.req_i[k] ? LW'(k) : lo_idx_s;
         hi_found_s = hi_found_s | (bus.req_i[k] & (LW'(k) > last_q));
         hi_idx_s   = (bus.req_i[k] && (LW'(k) > last_q)) ? LW'(k) : hi_idx_s;
      end
      win_found_s = lo_found_s;
      win_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
   end

   // Decode the winner index into a one-hot grant and select its byte.
   always_comb begin
      win_onehot_s = {N_REQ{1'b0}};
      win_byte_s   = 8'h00;
      for (int k = 0; k < N_REQ; k++) begin
         win_onehot_s[k] = (win_idx_s == LW'(k));
         win_byte_s      = (win_idx_s == LW'(k)) ? bus.data_i[8*k +: 8] : win_byte_s;
      end
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      timer_d = timer_q;
      last_d  = last_q;
      owner_d = owner_q;
      ack_d   = {N_REQ{1'b0}};
      err_d   = 1'b0;
      start_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (win_found_s && !bus.tx_busy_i) begin
               grant_d = win_onehot_s;
               data_d  = win_byte_s;
               owner_d = win_idx_s;
               start_d = 1'b1;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            timer_d = {TW{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A completing frame wins over a watchdog expiry on the same edge.
            if (bus.tx_done_i) begin
               ack_d   = grant_q;
               state_d = S_ACK;
            end else if (timer_q == TIMER_LAST) begin
               ack_d   = grant_q;
               err_d   = 1'b1;
               state_d = S_ABORT;
            end else begin
               timer_d = timer_q + TIMER_ONE;
            end
         end
         S_ACK, S_ABORT: begin
            last_d  = owner_q;
            grant_d = {N_REQ{1'b0}};
            state_d = S_IDLE;
         end
         default: begin
            grant_d = {N_REQ{1'b0}};
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any transfer in flight without an ack.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         grant_q <= {N_REQ{1'b0}};
         ack_q   <= {N_REQ{1'b0}};
         data_q  <= 8'h00;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         timer_q <= {TW{1'b0}};
         last_q  <= LAST_RST;
         owner_q <= {LW{1'b0}};
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         start_q <= start_d;
         err_q   <= err_d;
         timer_q <= timer_d;
         last_q  <= last_d;
         owner_q <= owner_d;
      end
   end

   assign bus.grant_o    = grant_q;
   assign bus.ack_o      = ack_q;
   assign bus.err_o      = err_q;
   assign bus.tx_start_o = start_q;
   assign bus.tx_data_o  = data_q;

endmodule
